// File: rtl/i_bits.sv
// Instruction buffer between the instruction read channel and decode.
// Accepted beats are queued with their fetch PC and issued one per cycle
// as a {valid, instr, pc} word. A taken jump flushes the queue and drops
// beats still in flight for the squashed path until jump_accept.
module i_bits #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,          // asynchronous, active-high despite the name
    input  logic        rvalid,
    input  logic        rlast,
    input  logic [31:0] rdata,
    input  logic [31:0] fetch_pc,
    input  logic        jump,
    input  logic        jump_wait,
    input  logic        jump_accept,
    input  logic        busy,
    output logic        rready,
    output logic [64:0] fetch_instr_pc,
    output logic        buf_full
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    // Storage: {instr, pc} per entry
    logic [63:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             discard_q, discard_d;
    logic [64:0]      out_q,    out_d;

    logic push_en;
    logic issue_en;
    logic pop_en;

    // Burst boundaries carry no meaning for storage; every beat is treated alike.
    logic unused_rlast;
    assign unused_rlast = rlast;

    assign buf_full       = (count_q == FULL_CNT);
    assign rready         = discard_q | (~buf_full & ~jump_wait);
    assign fetch_instr_pc = out_q;

    // Handshake decode: a jump overrides both intake and issue in its cycle
    always_comb begin
        push_en  = rvalid & rready & ~discard_q & ~jump;
        issue_en = ~busy & ~jump_wait & ~jump;
        pop_en   = issue_en & (count_q != '0);
    end

    // Next-state computation for pointers, occupancy, output word and discard flag
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        discard_d = discard_q;
        out_d     = out_q;

        if (jump) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            out_d[64] = 1'b0;
            discard_d = 1'b1;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
            // Issue reads the head before this cycle's push lands, so there is no bypass
            if (issue_en) begin
                if (pop_en) begin
                    out_d = {1'b1, mem[rd_ptr_q]};
                end else begin
                    out_d[64] = 1'b0;
                end
            end
            if (jump_accept) begin
                discard_d = 1'b0;
            end
        end
    end

    // Entry write; storage itself needs no reset since occupancy guards every read
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= {rdata, fetch_pc};
        end
    end

    // Control state registers with asynchronous clear
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            discard_q <= 1'b0;
            out_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            discard_q <= discard_d;
            out_q     <= out_d;
        end
    end

endmodule

// File: tb/tb_i_bits.sv
// Bench for i_bits: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_i_bits;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rvalid = 1'b0;
    logic        rlast = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] fetch_pc = '0;
    logic        jump = 1'b0;
    logic        jump_wait = 1'b0;
    logic        jump_accept = 1'b0;
    logic        busy = 1'b0;
    logic        rready;
    logic [64:0] fetch_instr_pc;
    logic        buf_full;

    int checks = 0;
    int errors = 0;

    i_bits #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rvalid         (rvalid),
        .rlast          (rlast),
        .rdata          (rdata),
        .fetch_pc       (fetch_pc),
        .jump           (jump),
        .jump_wait      (jump_wait),
        .jump_accept    (jump_accept),
        .busy           (busy),
        .rready         (rready),
        .fetch_instr_pc (fetch_instr_pc),
        .buf_full       (buf_full)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {instr, pc}, the expected output word, discard flag
    logic [63:0] mq[$];
    logic [64:0] m_out = '0;
    bit          m_disc = 1'b0;

    function automatic bit m_rready();
        return m_disc | ((mq.size() != DEPTH) & ~jump_wait);
    endfunction

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mq.delete();
            m_out  = '0;
            m_disc = 1'b0;
        end else if (jump) begin
            mq.delete();
            m_out[64] = 1'b0;
            m_disc    = 1'b1;
        end else begin
            bit acc;
            acc = rvalid && m_rready() && !m_disc;
            if (!busy && !jump_wait) begin
                if (mq.size() > 0) m_out = {1'b1, mq.pop_front()};
                else               m_out[64] = 1'b0;
            end
            if (acc) mq.push_back({rdata, fetch_pc});
            if (jump_accept) m_disc = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        checks++;
        if (fetch_instr_pc !== m_out) begin
            errors++;
            $display("FAIL model_out: got %h expected %h", fetch_instr_pc, m_out);
        end
        checks++;
        if (buf_full !== (mq.size() == DEPTH)) begin
            errors++;
            $display("FAIL model_full: got %b expected %b", buf_full, mq.size() == DEPTH);
        end
        checks++;
        if (rready !== m_rready()) begin
            errors++;
            $display("FAIL model_rready: got %b expected %b", rready, m_rready());
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic beat(input logic [31:0] ins, input logic [31:0] pc);
        rvalid   = 1'b1;
        rdata    = ins;
        fetch_pc = pc;
    endtask

    initial begin
        #1 rst_n = 1'b1;
        step();
        #1;
        chk("reset_out", fetch_instr_pc, 65'h0);
        chk("reset_full", {64'h0, buf_full}, 65'h0);
        rst_n = 1'b0;
        step();

        // Three beats, one-cycle latency each
        beat(32'h0000A0B7, 32'h0);
        #1 chk("rready_idle", {64'h0, rready}, 65'h1);
        step();
        beat(32'h004000EF, 32'h4);
        step();
        chk("beat0", fetch_instr_pc, {1'b1, 32'h0000A0B7, 32'h0});
        beat(32'h0000A137, 32'h8);
        step();
        chk("beat1", fetch_instr_pc, {1'b1, 32'h004000EF, 32'h4});
        rvalid = 1'b0;
        step();
        chk("beat2", fetch_instr_pc, {1'b1, 32'h0000A137, 32'h8});
        step();
        chk("empty_hold", fetch_instr_pc, {1'b0, 32'h0000A137, 32'h8});

        // Fill to DEPTH while decode is busy
        busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            beat(32'h1000_0000 + i, 32'h10 + 4 * i);
            step();
        end
        #1;
        chk("full_flag", {64'h0, buf_full}, 65'h1);
        chk("full_rready", {64'h0, rready}, 65'h0);
        chk("full_out_held", fetch_instr_pc, {1'b0, 32'h0000A137, 32'h8});
        rvalid = 1'b0;
        busy   = 1'b0;
        step();
        chk("drain_first", fetch_instr_pc, {1'b1, 32'h1000_0000, 32'h10});
        chk("drain_not_full", {64'h0, buf_full}, 65'h0);
        for (int i = 1; i < DEPTH; i++) begin
            step();
            chk("drain_seq", fetch_instr_pc, {1'b1, 32'h1000_0000 + i, 32'h10 + 4 * i});
        end
        step();

        // Flush on jump, discard in-flight beats until jump_accept
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(32'h2000_0000 + i, 32'h40 + 4 * i);
            step();
        end
        rvalid = 1'b0;
        busy   = 1'b0;
        jump   = 1'b1;
        step();
        jump = 1'b0;
        chk("jump_invalid", {64'h0, fetch_instr_pc[64]}, 65'h0);
        for (int i = 0; i < 3; i++) begin
            beat(32'h3000_0000 + i, 32'h100 + 4 * i);
            step();
        end
        beat(32'h3000_0003, 32'h10C);
        jump_accept = 1'b1;
        step();
        jump_accept = 1'b0;
        chk("discard_none", {64'h0, fetch_instr_pc[64]}, 65'h0);
        beat(32'h00000013, 32'h200);
        step();
        rvalid = 1'b0;
        step();
        chk("new_path", fetch_instr_pc, {1'b1, 32'h00000013, 32'h200});

        // jump_wait pauses intake and issue
        jump_wait = 1'b1;
        beat(32'h0000_0093, 32'h300);
        #1 chk("wait_rready", {64'h0, rready}, 65'h0);
        step();
        step();
        chk("wait_frozen", fetch_instr_pc, {1'b1, 32'h00000013, 32'h200});
        jump_wait = 1'b0;
        step();
        rvalid = 1'b0;
        step();
        chk("wait_resume", fetch_instr_pc, {1'b1, 32'h0000_0093, 32'h300});

        // Asynchronous reset with entries buffered
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(32'h4000_0000 + i, 32'h380 + 4 * i);
            step();
        end
        rvalid = 1'b0;
        rst_n  = 1'b1;
        #1;
        chk("async_rst_out", fetch_instr_pc, 65'h0);
        chk("async_rst_full", {64'h0, buf_full}, 65'h0);
        step();
        rst_n = 1'b0;
        busy  = 1'b0;
        beat(32'h0000_0513, 32'h400);
        step();
        rvalid = 1'b0;
        step();
        chk("post_rst_beat", fetch_instr_pc, {1'b1, 32'h0000_0513, 32'h400});

        // Continuous streaming across several pointer wraps
        for (int i = 0; i < 3 * DEPTH; i++) begin
            beat(32'h5000_0000 + i, 32'h1000 + 4 * i);
            step();
            if (i > 0) chk("wrap_pc", {33'h0, fetch_instr_pc[31:0]}, {33'h0, 32'h1000 + 4 * (i - 1)});
        end
        rvalid = 1'b0;
        step();
        chk("wrap_last", fetch_instr_pc, {1'b1, 32'h5000_0000 + 3 * DEPTH - 1, 32'h1000 + 4 * (3 * DEPTH - 1)});
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
